// File: rtl/ctrl_types_pkg.sv
// ============================================================================
// Module   : ctrl_types_pkg
// Purpose  : Shared cache-controller types: operations, controller response,
//            issuer FSM states and the queued command record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_types_pkg;

   localparam int C_KEY_WIDTH   = 16;
   localparam int C_VALUE_WIDTH = 32;

   // Codes 3'b100..3'b111 are reserved and never reach the controller.
   typedef enum logic [2:0] {
      OP_NOOP   = 3'b000,
      OP_READ   = 3'b001,
      OP_UPSERT = 3'b010,
      OP_DELETE = 3'b011
   } operation_e;

   typedef struct packed {
      logic done;
      logic error;
   } sub_cmd_t;

   typedef enum logic [1:0] {
      IS_IDLE   = 2'd0,
      IS_ISSUE  = 2'd1,
      IS_WAIT   = 2'd2,
      IS_REPORT = 2'd3
   } issuer_state_e;

   typedef struct packed {
      logic [2:0]               op;
      logic [C_KEY_WIDTH-1:0]   key;
      logic [C_VALUE_WIDTH-1:0] value;
   } cmd_t;

   function automatic logic op_is_reserved(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Small synchronous FIFO with show-ahead head and full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int C_CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [C_PTR_W-1:0] r_wr_ptr;
   logic [C_PTR_W-1:0] r_rd_ptr;
   logic [C_CNT_W-1:0] r_count;
   logic               w_do_push;
   logic               w_do_pop;

   function automatic logic [C_PTR_W-1:0] next_ptr(input logic [C_PTR_W-1:0] p);
      return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (r_count == C_CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/cmd_issuer.sv
// ============================================================================
// Module   : cmd_issuer
// Purpose  : Queues host commands and issues them one at a time to the cache
//            controller, returning results in order. CMD_ISSUER_TIMEOUT_EN
//            enables the response-wait timeout. Key/value widths must match
//            the cmd_t field widths in ctrl_types_pkg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_issuer
   import ctrl_types_pkg::*;
#(
   parameter int KEY_WIDTH      = C_KEY_WIDTH,
   parameter int VALUE_WIDTH    = C_VALUE_WIDTH,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   host_valid,
   output logic                   host_ready,
   input  logic [2:0]             host_op,
   input  logic [KEY_WIDTH-1:0]   host_key,
   input  logic [VALUE_WIDTH-1:0] host_value,
   output logic                   ctrl_valid,
   input  logic                   ctrl_ready,
   output logic [2:0]             ctrl_op,
   output logic [KEY_WIDTH-1:0]   ctrl_key,
   output logic [VALUE_WIDTH-1:0] ctrl_value,
   input  sub_cmd_t               ctrl_resp,
   input  logic [VALUE_WIDTH-1:0] ctrl_rd_value,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [2:0]             res_op,
   output logic                   res_error,
   output logic                   res_timeout,
   output logic [VALUE_WIDTH-1:0] res_value
);

   localparam int C_CMD_W = $bits(cmd_t);

   issuer_state_e          r_state;
   cmd_t                   r_cmd;
   logic                   r_ctrl_valid;
   logic                   r_res_valid;
   logic [2:0]             r_res_op;
   logic                   r_res_error;
   logic                   r_res_timeout;
   logic [VALUE_WIDTH-1:0] r_res_value;

   cmd_t                   w_host_cmd;
   cmd_t                   w_head_cmd;
   logic [C_CMD_W-1:0]     w_head_flat;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;

`ifdef CMD_ISSUER_TIMEOUT_EN
   localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [C_CNT_W-1:0] r_wait_cnt;
`endif

   assign w_host_cmd.op    = host_op;
   assign w_host_cmd.key   = host_key;
   assign w_host_cmd.value = host_value;
   assign w_head_cmd       = cmd_t'(w_head_flat);

   // NOOPs are acknowledged but never occupy a FIFO slot.
   assign host_ready = rst_n && !w_full;
   assign w_push     = host_valid && host_ready && (host_op != OP_NOOP);
   assign w_pop      = (r_state == IS_IDLE) && !w_empty;

   cmd_fifo #(
      .WIDTH (C_CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (w_host_cmd),
      .pop   (w_pop),
      .dout  (w_head_flat),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IS_IDLE;
         r_cmd         <= '0;
         r_ctrl_valid  <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_op      <= '0;
         r_res_error   <= 1'b0;
         r_res_timeout <= 1'b0;
         r_res_value   <= '0;
`ifdef CMD_ISSUER_TIMEOUT_EN
         r_wait_cnt    <= '0;
`endif
      end else begin
         case (r_state)
            IS_IDLE: begin
               if (!w_empty) begin
                  r_cmd <= w_head_cmd;
                  if (op_is_reserved(w_head_cmd.op)) begin
                     r_res_valid   <= 1'b1;
                     r_res_op      <= w_head_cmd.op;
                     r_res_error   <= 1'b1;
                     r_res_timeout <= 1'b0;
                     r_res_value   <= '0;
                     r_state       <= IS_REPORT;
                  end else begin
                     r_ctrl_valid  <= 1'b1;
                     r_state       <= IS_ISSUE;
                  end
               end
            end
            IS_ISSUE: begin
               if (ctrl_ready) begin
                  r_ctrl_valid <= 1'b0;
`ifdef CMD_ISSUER_TIMEOUT_EN
                  r_wait_cnt   <= '0;
`endif
                  r_state      <= IS_WAIT;
               end
            end
            IS_WAIT: begin
               if (ctrl_resp.done) begin
                  r_res_valid   <= 1'b1;
                  r_res_op      <= r_cmd.op;
                  r_res_error   <= ctrl_resp.error;
                  r_res_timeout <= 1'b0;
                  r_res_value   <= (r_cmd.op == OP_READ) ? ctrl_rd_value : '0;
                  r_state       <= IS_REPORT;
`ifdef CMD_ISSUER_TIMEOUT_EN
               end else if (r_wait_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_res_valid   <= 1'b1;
                  r_res_op      <= r_cmd.op;
                  r_res_error   <= 1'b1;
                  r_res_timeout <= 1'b1;
                  r_res_value   <= '0;
                  r_state       <= IS_REPORT;
               end else begin
                  r_wait_cnt    <= r_wait_cnt + 1'b1;
`endif
               end
            end
            IS_REPORT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= IS_IDLE;
               end
            end
            default: r_state <= IS_IDLE;
         endcase
      end
   end

   assign ctrl_valid  = r_ctrl_valid;
   assign ctrl_op     = r_cmd.op;
   assign ctrl_key    = r_cmd.key;
   assign ctrl_value  = r_cmd.value;
   assign res_valid   = r_res_valid;
   assign res_op      = r_res_op;
   assign res_error   = r_res_error;
   assign res_timeout = r_res_timeout;
   assign res_value   = r_res_value;

endmodule

`default_nettype wire

// File: tb/tb_cmd_issuer.sv
// ============================================================================
// Module   : tb_cmd_issuer
// Purpose  : Self-checking bench for cmd_issuer with a queue-based host and
//            controller model. Define CMD_ISSUER_TIMEOUT_EN for timeout build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_issuer;
   import ctrl_types_pkg::*;

   localparam int TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        host_valid, host_ready;
   logic [2:0]  host_op;
   logic [15:0] host_key;
   logic [31:0] host_value;
   logic        ctrl_valid, ctrl_ready;
   logic [2:0]  ctrl_op;
   logic [15:0] ctrl_key;
   logic [31:0] ctrl_value;
   sub_cmd_t    ctrl_resp;
   logic [31:0] ctrl_rd_value;
   logic        res_valid, res_ready, res_error, res_timeout;
   logic [2:0]  res_op;
   logic [31:0] res_value;

   always #5 clk = ~clk;

   cmd_issuer #(
      .KEY_WIDTH(16), .VALUE_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .host_valid(host_valid), .host_ready(host_ready), .host_op(host_op),
      .host_key(host_key), .host_value(host_value),
      .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_op(ctrl_op),
      .ctrl_key(ctrl_key), .ctrl_value(ctrl_value),
      .ctrl_resp(ctrl_resp), .ctrl_rd_value(ctrl_rd_value),
      .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
      .res_error(res_error), .res_timeout(res_timeout), .res_value(res_value)
   );

   typedef struct { logic [2:0] op; logic [15:0] key; logic [31:0] value; } tcmd_t;
   typedef struct { logic err; logic to; logic [31:0] val; } tresp_t;

   tcmd_t  acc_q[$];   // accepted, result still owed (FIFO order)
   tcmd_t  iss_q[$];   // accepted, still to be seen at the controller
   tresp_t resp_q[$];  // controller outcomes awaiting report

   int n_checks = 0, n_errors = 0;
   int ready_mode, rready_mode, dly_max, err_mode;
   bit resp_en, spur_en, fixed_rd_en;
   logic [31:0] fixed_rd;

   bit outstanding = 0;
   int countdown, wait_cnt;
   logic [2:0] out_op;
   int n_results, n_ctrl_valid;
   bit last_host_fire, last_ctrl_fire, last_res_fire;
   logic s_res_valid, s_res_error, s_res_timeout, s_host_ready;
   logic [2:0] s_res_op;
   logic [31:0] s_res_value;
   bit ctrl_hold = 0, res_hold = 0;
   logic [63:0] ctrl_vec, res_vec;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_rsvd(input logic [2:0] op);
      return op >= 3'b100;
   endfunction

   function automatic logic pick(input int mode);
      return (mode == 2) ? 1'($urandom_range(1, 0)) : (mode == 1);
   endfunction

   task automatic step();
      tcmd_t  c;
      tresp_t r;
      @(negedge clk);
      last_host_fire = 0; last_ctrl_fire = 0; last_res_fire = 0;
      s_res_valid = res_valid; s_res_op = res_op; s_res_error = res_error;
      s_res_timeout = res_timeout; s_res_value = res_value; s_host_ready = host_ready;
      if (!rst_n) begin
         acc_q.delete(); iss_q.delete(); resp_q.delete();
         outstanding = 0; ctrl_hold = 0; res_hold = 0;
      end else begin
         if (ctrl_valid) begin
            n_ctrl_valid++;
            check_val("single_outstanding", 64'(outstanding), 64'd0);
         end
         if (ctrl_hold)
            check_val("ctrl_stable", {12'd0, ctrl_valid, ctrl_op, ctrl_key, ctrl_value}, ctrl_vec);
         if (res_hold)
            check_val("res_stable", {26'd0, res_valid, res_op, res_error, res_timeout, res_value}, res_vec);
         ctrl_hold = ctrl_valid && !ctrl_ready;
         ctrl_vec  = {12'd0, ctrl_valid, ctrl_op, ctrl_key, ctrl_value};
         res_hold  = res_valid && !res_ready;
         res_vec   = {26'd0, res_valid, res_op, res_error, res_timeout, res_value};

         if (host_valid && host_ready) begin
            last_host_fire = 1;
            if (host_op != 3'(OP_NOOP)) begin
               c = '{host_op, host_key, host_value};
               acc_q.push_back(c);
               if (!is_rsvd(host_op)) iss_q.push_back(c);
            end
         end
         if (outstanding) begin
            if (ctrl_resp.done) begin
               r = '{ctrl_resp.error, 1'b0, (out_op == 3'(OP_READ)) ? ctrl_rd_value : 32'd0};
               resp_q.push_back(r);
               outstanding = 0;
            end else begin
               wait_cnt++;
`ifdef CMD_ISSUER_TIMEOUT_EN
               if (wait_cnt == TB_TIMEOUT) begin
                  resp_q.push_back('{1'b1, 1'b1, 32'd0});
                  outstanding = 0;
               end
`endif
            end
         end
         if (ctrl_valid && ctrl_ready) begin
            last_ctrl_fire = 1;
            check_val("ctrl_fire_expected", 64'(iss_q.size() != 0), 64'd1);
            if (iss_q.size() != 0) begin
               c = iss_q.pop_front();
               check_val("ctrl_op", 64'(ctrl_op), 64'(c.op));
               check_val("ctrl_key", 64'(ctrl_key), 64'(c.key));
               check_val("ctrl_value", 64'(ctrl_value), 64'(c.value));
            end
            outstanding = 1; wait_cnt = 0; out_op = ctrl_op;
            countdown = int'($urandom_range(dly_max, 0));
         end
         if (res_valid && res_ready) begin
            last_res_fire = 1;
            n_results++;
            check_val("res_expected", 64'(acc_q.size() != 0), 64'd1);
            if (acc_q.size() != 0) begin
               c = acc_q.pop_front();
               r = '{1'b1, 1'b0, 32'd0};
               if (!is_rsvd(c.op)) begin
                  check_val("resp_available", 64'(resp_q.size() != 0), 64'd1);
                  if (resp_q.size() != 0) r = resp_q.pop_front();
               end
               check_val("res_op", 64'(res_op), 64'(c.op));
               check_val("res_error", 64'(res_error), 64'(r.err));
               check_val("res_timeout", 64'(res_timeout), 64'(r.to));
               check_val("res_value", 64'(res_value), 64'(r.val));
            end
         end
      end
      @(posedge clk);
      #1;
      ctrl_ready    = pick(ready_mode);
      res_ready     = pick(rready_mode);
      ctrl_resp     = '0;
      ctrl_rd_value = $urandom;
      if (outstanding && resp_en) begin
         if (countdown == 0) begin
            ctrl_resp.done  = 1'b1;
            ctrl_resp.error = pick(err_mode);
            if (fixed_rd_en) ctrl_rd_value = fixed_rd;
         end else countdown--;
      end else if (!outstanding && spur_en && $urandom_range(3, 0) == 0) begin
         ctrl_resp.done  = 1'b1;
         ctrl_resp.error = 1'($urandom_range(1, 0));
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [15:0] key, input logic [31:0] val);
      int n = 0;
      host_valid = 1; host_op = op; host_key = key; host_value = val;
      do begin step(); n++; end while (!last_host_fire && n < 50);
      check_val("send_accepted", 64'(last_host_fire), 64'd1);
      host_valid = 0;
   endtask

   task automatic wait_result(input int budget);
      int n = 0;
      do begin step(); n++; end while (!last_res_fire && n < budget);
      check_val("result_in_budget", 64'(last_res_fire), 64'd1);
   endtask

   task automatic idle(input int n);
      host_valid = 0;
      repeat (n) step();
   endtask

   task automatic drain();
      int n = 0;
      host_valid = 0; ready_mode = 1; rready_mode = 1; resp_en = 1;
      while (acc_q.size() != 0 && n < 500) begin step(); n++; end
      check_val("drain_empty", 64'(acc_q.size()), 64'd0);
   endtask

   task automatic apply_reset();
      rst_n = 0;
      step(); step();
      check_val("rst_ctrl", {12'd0, ctrl_valid, ctrl_op, ctrl_key, ctrl_value}, 64'd0);
      check_val("rst_res", {26'd0, res_valid, res_op, res_error, res_timeout, res_value}, 64'd0);
      check_val("rst_host_ready", 64'(host_ready), 64'd0);
      rst_n = 1;
      step();
      check_val("ready_after_rst", 64'(s_host_ready), 64'd1);
   endtask

   initial begin
      int lat, n_acc;
      rst_n = 0; host_valid = 0; host_op = '0; host_key = '0; host_value = '0;
      ctrl_ready = 0; res_ready = 0; ctrl_resp = '0; ctrl_rd_value = '0;
      ready_mode = 1; rready_mode = 1; dly_max = 0; err_mode = 0;
      resp_en = 1; spur_en = 0; fixed_rd_en = 0; fixed_rd = '0;
      apply_reset();

      // READ with immediate ready/done: fixed latency and captured value
      fixed_rd_en = 1; fixed_rd = 32'hDEADBEEF;
      send(3'(OP_READ), 16'h0012, 32'h0);
      lat = 0;
      do begin step(); lat++; end while (!s_res_valid && lat < 20);
      check_val("read_latency", 64'(lat), 64'd4);
      check_val("read_value", 64'(s_res_value), 64'hDEADBEEF);
      check_val("read_op", 64'(s_res_op), 64'(OP_READ));
      check_val("read_err", 64'(s_res_error), 64'd0);
      fixed_rd_en = 0;
      idle(2);

      // Back-pressure: 5 UPSERTs with the controller stalled
      ready_mode = 0; n_acc = 0;
      host_valid = 1; host_op = 3'(OP_UPSERT);
      for (int i = 0; i < 5; i++) begin
         host_key = 16'(16'h0100 + i); host_value = $urandom;
         step();
         if (last_host_fire) n_acc++;
      end
      check_val("five_accepted", 64'(n_acc), 64'd5);
      host_key = 16'h01FF;
      step();
      check_val("full_ready_low", 64'(s_host_ready), 64'd0);
      check_val("full_no_accept", 64'(last_host_fire), 64'd0);
      n_results = 0;
      drain();
      check_val("five_results", 64'(n_results), 64'd5);

      // DELETE with controller error, then a reserved opcode
      err_mode = 1;
      send(3'(OP_DELETE), 16'h0033, 32'h44);
      wait_result(30);
      check_val("delete_err", 64'(s_res_error), 64'd1);
      check_val("delete_value", 64'(s_res_value), 64'd0);
      err_mode = 0;
      idle(2);
      n_ctrl_valid = 0;
      send(3'b101, 16'h0055, 32'h66);
      wait_result(30);
      check_val("rsvd_err", 64'(s_res_error), 64'd1);
      idle(3);
      check_val("rsvd_no_ctrl", 64'(n_ctrl_valid), 64'd0);

      // Reset while waiting on the controller with two queued
      resp_en = 0;
      send(3'(OP_UPSERT), 16'h0A01, 32'h1);
      send(3'(OP_UPSERT), 16'h0A02, 32'h2);
      send(3'(OP_UPSERT), 16'h0A03, 32'h3);
      idle(3);
      apply_reset();
      resp_en = 1; n_results = 0; n_ctrl_valid = 0;
      idle(10);
      check_val("rst_no_result", 64'(n_results), 64'd0);
      check_val("rst_no_ctrl", 64'(n_ctrl_valid), 64'd0);
      send(3'(OP_NOOP), 16'h0, 32'h0);
      idle(8);
      check_val("noop_no_result", 64'(n_results), 64'd0);
      check_val("noop_no_ctrl", 64'(n_ctrl_valid), 64'd0);

`ifdef CMD_ISSUER_TIMEOUT_EN
      // Controller never answers; later done must be ignored
      resp_en = 0;
      send(3'(OP_READ), 16'h0077, 32'h0);
      lat = 0;
      while (!last_ctrl_fire && lat < 20) begin step(); lat++; end
      lat = 0;
      do begin step(); lat++; end while (!s_res_valid && lat < 40);
      check_val("timeout_latency", 64'(lat), 64'd9);
      check_val("timeout_flag", 64'(s_res_timeout), 64'd1);
      check_val("timeout_err", 64'(s_res_error), 64'd1);
      check_val("timeout_value", 64'(s_res_value), 64'd0);
      resp_en = 1; spur_en = 1; n_results = 0;
      idle(8);
      check_val("late_done_ignored", 64'(n_results), 64'd0);
      dly_max = 12;
`else
      dly_max = 3;
`endif

      // Randomized traffic against the model
      ready_mode = 2; rready_mode = 2; err_mode = 2; resp_en = 1; spur_en = 1;
      for (int i = 0; i < 800; i++) begin
         host_valid = 1'($urandom_range(1, 0));
         host_op    = 3'($urandom_range(7, 0));
         host_key   = 16'($urandom);
         host_value = $urandom;
         step();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got expired expected finish");
      $fatal(1, "bench time limit reached");
   end

endmodule

`default_nettype wire

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 SHALL have parameters: KEY_WIDTH, 16, key bits; VALUE_WIDTH, 32, value bits; FIFO_DEPTH, 4, queued commands (power of two, >=2); TIMEOUT_CYCLES, 255, max response wait.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  synchronous active-low reset.
REQ-003 host_valid in 1, host_ready out 1, host_op in 3 (operation_e), host_key in KEY_WIDTH, host_value in VALUE_WIDTH: host command input.
REQ-004 ctrl_valid out 1, ctrl_ready in 1, ctrl_op out 3, ctrl_key out KEY_WIDTH, ctrl_value out VALUE_WIDTH: command to cache controller.
REQ-005 ctrl_resp in 2 (sub_cmd_t {done,error}), ctrl_rd_value in VALUE_WIDTH: controller response, sampled when ctrl_resp.done=1.
REQ-006 res_valid out 1, res_ready in 1, res_op out 3, res_error out 1, res_timeout out 1, res_value out VALUE_WIDTH: result to host.

Function
REQ-007 Host handshake: command accepted on clk edge with host_valid && host_ready; host_ready = FIFO not full.
REQ-008 Accepted NOOP SHALL be discarded (not queued, no result).
REQ-009 Accepted op codes 3'b100..3'b111 SHALL be queued and reported with res_error=1 without reaching the controller.
REQ-010 FIFO full: host_ready=0, no entry lost; simultaneous push and pop when full SHALL be disallowed (ready already 0); push and pop when non-full SHALL both occur, count unchanged.
REQ-011 FSM states (issuer_state_e): IS_IDLE, IS_ISSUE, IS_WAIT, IS_REPORT.
REQ-012 IS_IDLE: FIFO non-empty -> pop head into command register; valid op -> IS_ISSUE next cycle; reserved op -> IS_REPORT with res_error=1.
REQ-013 IS_ISSUE: ctrl_valid=1, ctrl_op/key/value held stable until ctrl_ready=1; on accept -> IS_WAIT, wait counter cleared.
REQ-014 IS_WAIT: ctrl_valid=0; ctrl_resp.done=1 -> capture error and ctrl_rd_value (value only for READ, else 0) -> IS_REPORT; done in same cycle as ctrl_ready accept SHALL be ignored.
REQ-015 IS_REPORT: res_valid=1, outputs stable until res_ready=1; on accept -> IS_IDLE; next command popped no earlier than the following cycle.
REQ-016 Minimum latency FIFO push to res_valid: 4 cycles with ctrl_ready and done returned immediately.
REQ-017 One command outstanding at the controller at any time; results in FIFO order.
REQ-018 ctrl_resp.done outside IS_WAIT SHALL be ignored.

Reset
REQ-019 rst_n=0 at clk edge: FSM IS_IDLE, FIFO empty, counter 0, all outputs 0 except host_ready=0 during reset, 1 the first cycle after.
REQ-020 Reset mid-operation SHALL drop queued and in-flight commands with no result emitted.

Configuration
REQ-021 CMD_ISSUER_TIMEOUT_EN defined: IS_WAIT counter increments per cycle; reaching TIMEOUT_CYCLES without done -> IS_REPORT with res_timeout=1, res_error=1, res_value=0; late done ignored.
REQ-022 CMD_ISSUER_TIMEOUT_EN undefined: no counter, IS_WAIT waits indefinitely, res_timeout tied 0.

Structure
REQ-023 issuer_state_e and packed cmd_t {op, key, value} SHALL be added to ctrl_types_pkg; operation_e and sub_cmd_t reused from it.
REQ-024 FIFO SHALL be sub-module cmd_fifo (parameterised width/depth, pointer wrap at FIFO_DEPTH, full/empty flags).

Verification
REQ-025 READ key=0x0012, ctrl_ready=1, done=1 error=0 rd_value=0xDEADBEEF next cycle -> res_valid, res_op=READ, res_value=0xDEADBEEF, res_error=0.
REQ-026 Push 5 UPSERTs with ctrl_ready=0 -> host_ready=0 after 4th FIFO entry (1 popped into issue register), no loss; release -> 5 results in order.
REQ-027 DELETE, controller returns done=1 error=1 -> res_error=1, res_value=0; host_op=3'b101 -> res_error=1, ctrl_valid never asserted.
REQ-028 TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> res_timeout=1 after 8 IS_WAIT cycles; later done ignored.
REQ-029 Reset asserted in IS_WAIT with 2 queued -> all outputs 0, no res_valid after release; NOOP push -> no ctrl_valid, no result.
